aes_job_initiator: RTL and testbench

- Master-side sequencer that drives the aes_top start/done interface on behalf of a streaming client.
- Accepts (block, key, mode) jobs on a valid/ready input port and launches each one with a single-cycle start pulse.
- Waits for done, captures the core's result and presents it on a valid/ready output port.
- Sits between the DMA/stream fabric and aes_top; exactly one job is outstanding at a time.

---
 rtl/aes_job_initiator.sv | 136 +++++++++++++
 tb/tb_aes_job_initiator.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_initiator.sv
// aes_job_initiator
//   Master-side sequencer between a streaming client and aes_top. It accepts one
//   (block, key, mode) job at a time on a valid/ready input port, launches it with a
//   single-cycle start pulse and waits for done. The core's result is then presented on
//   a valid/ready output port until the consumer takes it.
//
//   Optional feature: define AES_INIT_TIMEOUT_EN to bound the start-to-done wait to
//   TIMEOUT_CYCLES. A job that times out returns a zero block and sets the sticky
//   err_timeout port.
//
// Ports
//   clk, rst                   clock and asynchronous active-high reset
//   in_valid/in_ready          job handshake; in_data, in_key, in_encrypt carry the job
//   core_start                 one-cycle launch pulse to aes_top
//   core_encrypt/data_in/key_in  job operands, held from launch until the next job
//   core_data_out/busy/done    aes_top status and result (done: pulse or level)
//   out_valid/out_ready        result handshake; out_data and out_encrypt carry the result
//   job_count                  results accepted on the output port (wraps)
//   err_timeout                sticky timeout flag (AES_INIT_TIMEOUT_EN only)

module aes_job_initiator #(
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   input  logic [127:0]     in_key,
   input  logic             in_encrypt,
   output logic             core_start,
   output logic             core_encrypt,
   output logic [127:0]     core_data_in,
   output logic [127:0]     core_key_in,
   input  logic [127:0]     core_data_out,
   input  logic             core_busy,
   input  logic             core_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic             out_encrypt,
`ifdef AES_INIT_TIMEOUT_EN
   output logic             err_timeout,
`endif
   output logic [CNT_W-1:0] job_count
);

   typedef enum logic [1:0] {StIdle, StLaunch, StWait, StHold} state_e;

   state_e state;
   // High only during the first WAIT cycle, so a level done left over from the
   // previous job is not mistaken for this job's completion.
   logic   wait_first;

`ifdef AES_INIT_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TmoW-1:0] tmo_cnt;
`endif

   // Combinational so a job can be taken the same cycle the core goes idle.
   assign in_ready = !rst && (state == StIdle) && !core_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= StIdle;
         wait_first   <= 1'b0;
         core_start   <= 1'b0;
         core_encrypt <= 1'b1;
         core_data_in <= '0;
         core_key_in  <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_encrypt  <= 1'b0;
         job_count    <= '0;
`ifdef AES_INIT_TIMEOUT_EN
         tmo_cnt      <= '0;
         err_timeout  <= 1'b0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid && in_ready) begin
                  core_data_in <= in_data;
                  core_key_in  <= in_key;
                  core_encrypt <= in_encrypt;
                  core_start   <= 1'b1;
                  state        <= StLaunch;
               end
            end

            StLaunch: begin
               core_start <= 1'b0;
               wait_first <= 1'b1;
`ifdef AES_INIT_TIMEOUT_EN
               tmo_cnt    <= '0;
`endif
               state      <= StWait;
            end

            StWait: begin
               wait_first <= 1'b0;
               if (!wait_first && core_done) begin
                  out_data    <= core_data_out;
                  out_encrypt <= core_encrypt;
                  out_valid   <= 1'b1;
                  state       <= StHold;
               end
`ifdef AES_INIT_TIMEOUT_EN
               // Counter reads TIMEOUT_CYCLES-1 in the last allowed WAIT cycle.
               else if (tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1)) begin
                  out_data    <= '0;
                  out_encrypt <= core_encrypt;
                  out_valid   <= 1'b1;
                  err_timeout <= 1'b1;
                  state       <= StHold;
               end else begin
                  tmo_cnt <= tmo_cnt + TmoW'(1);
               end
`endif
            end

            StHold: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  job_count <= job_count + CNT_W'(1);
                  state     <= StIdle;
               end
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_job_initiator.sv
// Bench for aes_job_initiator: a behavioural core stands in for aes_top. It returns
// the FIPS-197 vector for the known key/block pair and data^key otherwise, with a
// selectable pulse or level done and a never-done mode. Results go through a
// scoreboard queue that a negedge monitor drains.

module tb_aes_job_initiator;

   localparam int unsigned CNT_W = 2;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     in_data;
   logic [127:0]     in_key;
   logic             in_encrypt;
   logic             core_start;
   logic             core_encrypt;
   logic [127:0]     core_data_in;
   logic [127:0]     core_key_in;
   logic [127:0]     core_data_out;
   logic             core_busy;
   logic             core_done;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out_data;
   logic             out_encrypt;
   logic [CNT_W-1:0] job_count;
`ifdef AES_INIT_TIMEOUT_EN
   logic             err_timeout;
`endif

   aes_job_initiator #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_key        (in_key),
      .in_encrypt    (in_encrypt),
      .core_start    (core_start),
      .core_encrypt  (core_encrypt),
      .core_data_in  (core_data_in),
      .core_key_in   (core_key_in),
      .core_data_out (core_data_out),
      .core_busy     (core_busy),
      .core_done     (core_done),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_encrypt   (out_encrypt),
`ifdef AES_INIT_TIMEOUT_EN
      .err_timeout   (err_timeout),
`endif
      .job_count     (job_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural core ----------------
   logic         m_level = 1'b0;
   logic         m_never = 1'b0;
   int           m_lat   = 3;
   int           m_cnt;
   logic         m_pending;
   logic         m_drop;
   logic [127:0] m_d, m_k;
   logic         m_e;

   function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k,
                                            input logic e);
      if (e && d == PT && k == KEY) return CT;
      if (!e && d == CT && k == KEY) return PT;
      return d ^ k;
   endfunction

   initial begin
      core_done = 1'b0; core_busy = 1'b0; core_data_out = '0;
      m_pending = 1'b0; m_drop = 1'b0; m_cnt = 0;
   end

   always @(posedge clk) begin
      if (core_start) begin
         m_d       <= core_data_in;
         m_k       <= core_key_in;
         m_e       <= core_encrypt;
         m_cnt     <= m_lat;
         m_pending <= 1'b1;
         core_busy <= 1'b1;
         // Level mode keeps the stale done high into the first WAIT cycle.
         if (m_level) m_drop <= 1'b1;
         else core_done <= 1'b0;
      end else begin
         if (m_drop) begin
            core_done <= 1'b0;
            m_drop    <= 1'b0;
         end else if (!m_level) begin
            core_done <= 1'b0;
         end
         if (m_pending && !m_never) begin
            if (m_cnt == 0) begin
               core_done     <= 1'b1;
               core_data_out <= core_fn(m_d, m_k, m_e);
               core_busy     <= 1'b0;
               m_pending     <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   // ---------------- scoreboard and monitors ----------------
   typedef struct {
      logic [127:0]     data;
      logic             enc;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t             sb[$];
   logic [CNT_W-1:0] exp_cnt = '0;
   int               starts  = 0;
   logic             prev_start = 1'b0;

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", out_valid, 1'b0);
         end else if (out_ready) begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_encrypt", out_encrypt, e.enc);
            check("job_count_at_accept", job_count, e.cnt);
         end
      end
   end

   always @(negedge clk) begin
      if (core_start) begin
         starts++;
         check("start_single_cycle", prev_start, 1'b0);
      end
      prev_start = core_start;
   end

   // ---------------- driver helpers ----------------
   task automatic send(input logic [127:0] d, input logic [127:0] k, input logic e,
                       input logic [127:0] exp_d, input logic push);
      int   n;
      exp_t item;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("in_ready_wait", in_ready, 1'b1);
         return;
      end
      if (push) begin
         item.data = exp_d;
         item.enc  = e;
         item.cnt  = exp_cnt;
         sb.push_back(item);
         exp_cnt = exp_cnt + 1'b1;
      end
      in_valid = 1'b1; in_data = d; in_key = k; in_encrypt = e;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("launch_start", core_start, 1'b1);
      check("launch_data", core_data_in, d);
      check("launch_key", core_key_in, k);
      check("launch_encrypt", core_encrypt, e);
      check("launch_in_ready", in_ready, 1'b0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 128'(sb.size()), 128'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; in_encrypt = 1'b0;
      out_ready = 1'b1;
      #12;
      check("rst_core_start", core_start, 1'b0);
      check("rst_core_encrypt", core_encrypt, 1'b1);
      check("rst_core_data_in", core_data_in, 128'd0);
      check("rst_core_key_in", core_key_in, 128'd0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 128'd0);
      check("rst_out_encrypt", out_encrypt, 1'b0);
      check("rst_job_count", job_count, 128'd0);
      check("rst_in_ready", in_ready, 1'b0);
`ifdef AES_INIT_TIMEOUT_EN
      check("rst_err_timeout", err_timeout, 1'b0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Reset three cycles after the launch pulse abandons the job.
      m_lat = 10;
      send(128'habcd, 128'h1234, 1'b1, 128'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_core_start", core_start, 1'b0);
      check("midrst_core_encrypt", core_encrypt, 1'b1);
      check("midrst_core_data_in", core_data_in, 128'd0);
      check("midrst_core_key_in", core_key_in, 128'd0);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_data", out_data, 128'd0);
      check("midrst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("midrst_job_count", job_count, 128'd0);
      m_lat = 3;

      // FIPS-197 encrypt then decrypt.
      send(PT, KEY, 1'b1, CT, 1'b1);
      drain();
      @(negedge clk);
      check("count_after_enc", job_count, 128'd1);
      send(CT, KEY, 1'b0, PT, 1'b1);
      drain();
      @(negedge clk);
      check("count_after_dec", job_count, 128'd2);

      // Backpressure: result held 20 cycles while a new job is offered.
      out_ready = 1'b0;
      send(128'hdeadbeef_00000000_cafef00d_12345678, 128'h00000000_ffffffff_0000ffff_11111111,
           1'b1, 128'hdeadbeef_ffffffff_cafe0ff2_03254769, 1'b1);
      begin
         int n;
         n = 0;
         while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      in_valid = 1'b1; in_data = 128'h77; in_key = 128'h0; in_encrypt = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_out_data", out_data, 128'hdeadbeef_ffffffff_cafe0ff2_03254769);
         check("bp_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_out_valid", out_valid, 1'b0);
      check("bp_release_in_ready", in_ready, 1'b1);
      drain();

      // Level-style done held high across back-to-back jobs; job_count wraps.
      m_level = 1'b1;
      send(128'h1, 128'h2, 1'b1, 128'h3, 1'b1);
      drain();
      send(128'h10, 128'h20, 1'b0, 128'h30, 1'b1);
      drain();
      @(negedge clk);
      check("count_after_wrap", job_count, 128'd1);

`ifdef AES_INIT_TIMEOUT_EN
      // Core never completes: timeout result appears in cycle LAUNCH+9.
      m_level = 1'b0;
      m_never = 1'b1;
      send(128'h55, 128'h0, 1'b1, 128'd0, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         if (k < 9) begin
            check("tmo_early_out_valid", out_valid, 1'b0);
         end else begin
            check("tmo_out_valid", out_valid, 1'b1);
            check("tmo_out_data", out_data, 128'd0);
            check("tmo_err", err_timeout, 1'b1);
         end
      end
      @(posedge clk);
      #1;
      check("tmo_after_hs_out_valid", out_valid, 1'b0);
      check("tmo_err_sticky", err_timeout, 1'b1);
      drain();
      check("start_count", 128'(starts), 128'd7);
`else
      check("start_count", 128'(starts), 128'd6);
`endif
      check("final_job_count", job_count, exp_cnt);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
